// File: rtl/core_mem_pkg.sv
// Shared constants and helpers for the core's data-memory path:
// width codes, opcode classes, responder FSM encodings and load extension.
package core_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [6:0] LOADS  = 7'b0000011;
    localparam logic [6:0] STORES = 7'b0100011;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic        is_wr;
    } req_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3)
            3'b000, 3'b100: m = 1'b0;
            3'b001, 3'b101: m = off[0];
            3'b010:         m = (off != 2'b00);
            default:        m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            LB:      r = {{24{b[7]}}, b};
            LH:      r = {{16{h[15]}}, h};
            LW:      r = word;
            LBU:     r = {24'h000000, b};
            LHU:     r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the core controller (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        RREQ;
    logic        CWE;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [2:0]  FUNCT3;
    logic [31:0] RDATA;
    logic        RDY;
    logic        BUSY;
    logic        MISALIGN;

    modport master (output RREQ, CWE, ADDR, WDATA, FUNCT3,
                    input  RDATA, RDY, BUSY, MISALIGN);
    modport slave  (input  RREQ, CWE, ADDR, WDATA, FUNCT3,
                    output RDATA, RDY, BUSY, MISALIGN);
endinterface

// File: rtl/dmem_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_lane_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             re_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // byte-lane writes and registered word read
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store, waits a fixed latency,
// then completes it with a single-cycle RDY pulse.
import core_mem_pkg::*;

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic             CLK,
    input  logic             RST,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic        misalign_q, misalign_d;

    logic        mis_s;
    logic        ram_re_s;
    logic [3:0]  lane_be_s;
    logic [3:0]  ram_be_s;
    logic [31:0] lane_wd_s;
    logic [31:0] ram_rd_s;
    logic        unused_addr_s;

    assign mis_s         = is_misaligned(req_q.funct3, req_q.addr[1:0]);
    assign unused_addr_s = ^req_q.addr[31:IDX_W+2];

    // store lane placement from width code and byte offset
    always_comb begin
        lane_be_s = 4'b0000;
        lane_wd_s = req_q.wdata;
        case (req_q.funct3[1:0])
            2'b00: begin
                lane_be_s = 4'b0001 << req_q.addr[1:0];
                lane_wd_s = {4{req_q.wdata[7:0]}};
            end
            2'b01: begin
                lane_be_s = req_q.addr[1] ? 4'b1100 : 4'b0011;
                lane_wd_s = {2{req_q.wdata[15:0]}};
            end
            2'b10: begin
                lane_be_s = 4'b1111;
                lane_wd_s = req_q.wdata;
            end
            default: begin
                lane_be_s = 4'b0000;
                lane_wd_s = req_q.wdata;
            end
        endcase
    end

    // read one edge before completion; write only on the completing edge so
    // a reset anywhere earlier leaves memory untouched
    assign ram_re_s = (state_q == ST_WAIT) && (cnt_q == 4'd1);
    assign ram_be_s = ((state_q == ST_WAIT) && (cnt_q == 4'd0) && req_q.is_wr && !mis_s)
                      ? lane_be_s : 4'b0000;

    dmem_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk_i   (CLK),
        .idx_i   (req_q.addr[IDX_W+1:2]),
        .re_i    (ram_re_s),
        .be_i    (ram_be_s),
        .wdata_i (lane_wd_s),
        .rdata_o (ram_rd_s)
    );

    // request FSM next-state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        rdy_d      = rdy_q;
        busy_d     = busy_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CWE || bus.RREQ) begin
                    req_d.addr   = bus.ADDR;
                    req_d.wdata  = bus.WDATA;
                    req_d.funct3 = bus.FUNCT3;
                    req_d.is_wr  = bus.CWE;
                    cnt_d        = CNT_LOAD;
                    busy_d       = 1'b1;
                    state_d      = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdy_d      = 1'b1;
                    misalign_d = mis_s;
                    state_d    = ST_RESP;
                    if (req_q.is_wr) begin
                        rdata_d = rdata_q;
                    end else if (mis_s) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = load_extend(req_q.funct3, req_q.addr[1:0], ram_rd_s);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rdy_d      = 1'b0;
                busy_d     = 1'b0;
                misalign_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                rdy_d      = 1'b0;
                busy_d     = 1'b0;
                misalign_d = 1'b0;
                cnt_d      = 4'd0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            req_q      <= '0;
            rdata_q    <= 32'h0000_0000;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.RDATA    = rdata_q;
    assign bus.RDY      = rdy_q;
    assign bus.BUSY     = busy_q;
    assign bus.MISALIGN = misalign_q;

endmodule
